// File: rtl/cim_xbar_responder.sv
// Cycle-level model of one CIM crossbar tile: the responder end of the fc_layer CIM interface.
// It stores a weight array and an input vector, runs an unsigned matrix-vector multiply on a
// start pulse (one crossbar row per cycle), and returns narrowed per-column results on a
// registered read port.
//
// Optional feature macro: CIM_SATURATE_EN
//   defined   -> results saturate at 2**datatype_size-1
//   undefined -> results keep the low datatype_size bits of the accumulator (wrap)
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   i_wgt_we/row/col/data    weight write (accepted in IDLE only)
//   i_cim_we/wr_addr/data    input-vector write (accepted in IDLE only)
//   i_cim_start      start-MVM pulse (accepted in IDLE only)
//   o_cim_busy       registered, high from the cycle after start until the first IDLE cycle
//   i_cim_rd_addr    result column index
//   o_data           res[i_cim_rd_addr], one cycle of latency
module cim_xbar_responder #(
  parameter int unsigned xbar_size     = 256,
  parameter int unsigned datatype_size = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_wgt_we,
  input  logic [$clog2(xbar_size)-1:0] i_wgt_row,
  input  logic [$clog2(xbar_size)-1:0] i_wgt_col,
  input  logic [datatype_size-1:0]     i_wgt_data,
  input  logic                         i_cim_we,
  input  logic [$clog2(xbar_size)-1:0] i_cim_wr_addr,
  input  logic [datatype_size-1:0]     i_cim_data,
  input  logic                         i_cim_start,
  output logic                         o_cim_busy,
  input  logic [$clog2(xbar_size)-1:0] i_cim_rd_addr,
  output logic [datatype_size-1:0]     o_data
);

  localparam int unsigned addr_w   = $clog2(xbar_size);
  // Wide enough that xbar_size products of two datatype_size values never overflow.
  localparam int unsigned acc_size = 2 * datatype_size + addr_w;

  typedef enum logic [1:0] {StIdle, StCompute, StDone} state_e;

  state_e                    state_q, state_d;
  logic [addr_w-1:0]         row_q, row_d;
  logic                      busy_q;
  logic [datatype_size-1:0]  w_q      [xbar_size][xbar_size];
  logic [datatype_size-1:0]  in_vec_q [xbar_size];
  logic [acc_size-1:0]       acc_q    [xbar_size];
  logic [datatype_size-1:0]  res_q    [xbar_size];
  logic [datatype_size-1:0]  data_q;

  logic idle, start_ok;
  assign idle     = (state_q == StIdle);
  assign start_ok = idle && i_cim_start;

  function automatic logic [datatype_size-1:0] narrow(input logic [acc_size-1:0] a);
`ifdef CIM_SATURATE_EN
    if (a[acc_size-1:datatype_size] != '0) return '1;
    return a[datatype_size-1:0];
`else
    return a[datatype_size-1:0];
`endif
  endfunction

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    unique case (state_q)
      StIdle: begin
        if (i_cim_start) begin
          state_d = StCompute;
          row_d   = '0;
        end
      end
      StCompute: begin
        row_d = row_q + 1'b1;
        if (row_q == addr_w'(xbar_size - 1)) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Busy is registered from the next state so it covers COMPUTE and DONE exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      row_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      busy_q  <= (state_d != StIdle);
    end
  end

  // Weights and input vector are frozen outside IDLE. A write coinciding with start lands at
  // the same edge, before row 0 is consumed, so the MVM sees the new value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < int'(xbar_size); r++) begin
        in_vec_q[r] <= '0;
        for (int c = 0; c < int'(xbar_size); c++) w_q[r][c] <= '0;
      end
    end else if (idle) begin
      if (i_wgt_we) w_q[i_wgt_row][i_wgt_col] <= i_wgt_data;
      if (i_cim_we) in_vec_q[i_cim_wr_addr] <= i_cim_data;
    end
  end

  // Accumulators: cleared on an accepted start, one row folded in per COMPUTE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < int'(xbar_size); c++) acc_q[c] <= '0;
    end else if (start_ok) begin
      for (int c = 0; c < int'(xbar_size); c++) acc_q[c] <= '0;
    end else if (state_q == StCompute) begin
      for (int c = 0; c < int'(xbar_size); c++) begin
        acc_q[c] <= acc_q[c] + acc_size'(in_vec_q[row_q]) * acc_size'(w_q[row_q][c]);
      end
    end
  end

  // Results hold until the next DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < int'(xbar_size); c++) res_q[c] <= '0;
    end else if (state_q == StDone) begin
      for (int c = 0; c < int'(xbar_size); c++) res_q[c] <= narrow(acc_q[c]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_q <= '0;
    else     data_q <= res_q[i_cim_rd_addr];
  end

  assign o_cim_busy = busy_q;
  assign o_data     = data_q;

endmodule

// File: tb/tb_cim_xbar_responder.sv
module tb_cim_xbar_responder;
  localparam int XS = 4;
  localparam int DS = 2;
  localparam int AW = 2;
  localparam int MAXV = (1 << DS) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_wgt_we = 1'b0;
  logic [AW-1:0] i_wgt_row = '0, i_wgt_col = '0;
  logic [DS-1:0] i_wgt_data = '0;
  logic          i_cim_we = 1'b0;
  logic [AW-1:0] i_cim_wr_addr = '0;
  logic [DS-1:0] i_cim_data = '0;
  logic          i_cim_start = 1'b0;
  logic          o_cim_busy;
  logic [AW-1:0] i_cim_rd_addr = '0;
  logic [DS-1:0] o_data;

  cim_xbar_responder #(.xbar_size(XS), .datatype_size(DS)) dut (
    .clk(clk), .rst(rst),
    .i_wgt_we(i_wgt_we), .i_wgt_row(i_wgt_row), .i_wgt_col(i_wgt_col), .i_wgt_data(i_wgt_data),
    .i_cim_we(i_cim_we), .i_cim_wr_addr(i_cim_wr_addr), .i_cim_data(i_cim_data),
    .i_cim_start(i_cim_start), .o_cim_busy(o_cim_busy),
    .i_cim_rd_addr(i_cim_rd_addr), .o_data(o_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];
  int mon_exp;
  logic rd_req = 1'b0;
  logic rd_vld = 1'b0;

  // Reference model state.
  int w_m [XS][XS];
  int in_m[XS];
  int res_m[XS];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int narrow(input int a);
`ifdef CIM_SATURATE_EN
    return (a > MAXV) ? MAXV : a;
`else
    return a % (MAXV + 1);
`endif
  endfunction

  function automatic void model_mvm();
    for (int c = 0; c < XS; c++) begin
      int s = 0;
      for (int r = 0; r < XS; r++) s += in_m[r] * w_m[r][c];
      res_m[c] = narrow(s);
    end
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < XS; r++) begin
      in_m[r] = 0;
      res_m[r] = 0;
      for (int c = 0; c < XS; c++) w_m[r][c] = 0;
    end
  endfunction

  // Monitor: a read issued in one cycle is checked on the negedge after the following edge.
  always @(posedge clk) rd_vld <= rd_req;

  always @(negedge clk) begin
    if (rd_vld) begin
      if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        mon_exp = exp_q.pop_front();
        chk("o_data", int'(o_data), mon_exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_w(input int r, input int c, input int d);
    i_wgt_we = 1'b1; i_wgt_row = AW'(r); i_wgt_col = AW'(c); i_wgt_data = DS'(d);
    w_m[r][c] = d;
    tick();
    i_wgt_we = 1'b0;
  endtask

  task automatic wr_in(input int r, input int d);
    i_cim_we = 1'b1; i_cim_wr_addr = AW'(r); i_cim_data = DS'(d);
    in_m[r] = d;
    tick();
    i_cim_we = 1'b0;
  endtask

  task automatic read(input int a);
    i_cim_rd_addr = AW'(a);
    rd_req = 1'b1;
    exp_q.push_back(res_m[a]);
    tick();
    rd_req = 1'b0;
  endtask

  task automatic read_all();
    for (int a = 0; a < XS; a++) read(a);
  endtask

  task automatic load_identity();
    for (int r = 0; r < XS; r++)
      for (int c = 0; c < XS; c++) wr_w(r, c, (r == c) ? 1 : 0);
  endtask

  task automatic load_in(input int a0, input int a1, input int a2, input int a3);
    wr_in(0, a0); wr_in(1, a1); wr_in(2, a2); wr_in(3, a3);
  endtask

  // Start an MVM (optionally with a same-cycle input write), read randomly while busy, and
  // return in the first IDLE cycle. poke pulses start plus a write mid-COMPUTE.
  task automatic run(input bit same_wr, input int wa, input int wd, input bit poke);
    int n = 0;
    i_cim_start = 1'b1;
    if (same_wr) begin
      i_cim_we = 1'b1; i_cim_wr_addr = AW'(wa); i_cim_data = DS'(wd);
      in_m[wa] = wd;
    end
    tick();
    i_cim_start = 1'b0; i_cim_we = 1'b0;
    while (o_cim_busy === 1'b1 && n < XS + 6) begin
      if (poke && n == 1) begin
        i_cim_start = 1'b1; i_cim_we = 1'b1; i_cim_wr_addr = '0; i_cim_data = DS'(3);
      end else begin
        i_cim_start = 1'b0; i_cim_we = 1'b0;
      end
      // Results must still show the previous MVM throughout the busy window.
      i_cim_rd_addr = AW'($urandom_range(0, XS - 1));
      rd_req = 1'b1;
      exp_q.push_back(res_m[i_cim_rd_addr]);
      n++;
      tick();
    end
    i_cim_start = 1'b0; i_cim_we = 1'b0; rd_req = 1'b0;
    chk("busy_cycles", n, XS + 1);
    model_mvm();
  endtask

  initial begin
    model_clear();
    tick(); tick();
    rst = 1'b0;
    chk("reset_busy", int'(o_cim_busy), 0);
    read_all();

    // Reset in the middle of COMPUTE.
    for (int r = 0; r < XS; r++) for (int c = 0; c < XS; c++) wr_w(r, c, $urandom_range(0, MAXV));
    for (int r = 0; r < XS; r++) wr_in(r, $urandom_range(1, MAXV));
    i_cim_start = 1'b1; tick(); i_cim_start = 1'b0;
    tick();
    chk("busy_mid_compute", int'(o_cim_busy), 1);
    rst = 1'b1;
    #1;
    chk("async_reset_busy", int'(o_cim_busy), 0);
    chk("async_reset_data", int'(o_data), 0);
    tick();
    rst = 1'b0;
    model_clear();
    read_all();

    // Identity weights, in = [1,2,3,0].
    load_identity();
    load_in(1, 2, 3, 0);
    run(1'b0, 0, 0, 1'b0);
    read_all();

    // All 3s: accumulator reaches 36.
    for (int r = 0; r < XS; r++) for (int c = 0; c < XS; c++) wr_w(r, c, 3);
    load_in(3, 3, 3, 3);
    run(1'b0, 0, 0, 1'b0);
    read_all();

    // Writes and start during COMPUTE are ignored; single busy window.
    load_identity();
    load_in(1, 2, 3, 0);
    run(1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("no_second_window", int'(o_cim_busy), 0);
      read(i);
    end
    read_all();

    // Same-cycle start and write of in_vec[3]=1.
    run(1'b1, 3, 1, 1'b0);
    read_all();

    // Back-to-back: start in the first IDLE cycle after DONE, with a new input value.
    run(1'b0, 0, 0, 1'b0);
    run(1'b1, 0, 2, 1'b0);
    read_all();

    // Randomised MVMs.
    for (int it = 0; it < 6; it++) begin
      for (int r = 0; r < XS; r++)
        for (int c = 0; c < XS; c++) wr_w(r, c, $urandom_range(0, MAXV));
      for (int r = 0; r < XS; r++) wr_in(r, $urandom_range(0, MAXV));
      run(1'b0, 0, 0, 1'b0);
      for (int k = 0; k < 6; k++) read($urandom_range(0, XS - 1));
    end

    tick(); tick();
    chk("sb_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
